// File: rtl/audio_i2s_tx.sv
// I2S transmitter: frame FIFO feeding a BCK/LRCK/DATA serializer with one-BCK data lag.
// Optional saturating underrun counter enabled by macro I2S_UNDERRUN_CNT_EN.
module audio_i2s_tx #(
  parameter int SAMPLE_BITS = 16,
  parameter int CHANNELS    = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int CLK_DIV     = 2
) (
  input  logic                              CLOCK_IN,
  input  logic                              RESET_N,
  input  logic [CHANNELS*SAMPLE_BITS-1:0]   SAMPLE_DATA,
  input  logic                              SAMPLE_VALID,
  output logic                              SAMPLE_READY,
  output logic                              I2S_BCK,
  output logic                              I2S_LRCK,
  output logic                              I2S_DATA,
  output logic [$clog2(FIFO_DEPTH):0]       FIFO_LEVEL,
`ifdef I2S_UNDERRUN_CNT_EN
  output logic [15:0]                       UNDERRUN_CNT,
`endif
  output logic                              UNDERRUN
);
  localparam int FRAME = CHANNELS * SAMPLE_BITS;
  localparam int KW    = $clog2(FRAME);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int DW    = $clog2(CLK_DIV);
  localparam logic [KW-1:0] K_LAST = KW'(FRAME - 1);
  localparam logic [KW-1:0] K_HALF = KW'(FRAME / 2);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]    div;
  logic [KW-1:0]    k, k_next;
  logic [AW-1:0]    wptr, rptr;
  logic [FRAME-1:0] mem [FIFO_DEPTH];
  logic [FRAME-1:0] head, head_ser, sreg;
  logic             wrap, fall, load, empty, wr, rd;

  assign wrap   = (div == D_LAST);
  assign fall   = wrap && I2S_BCK;
  assign k_next = (k == K_LAST) ? '0 : k + 1'b1;
  assign load   = fall && (k == K_LAST);
  assign empty  = (FIFO_LEVEL == '0);
  assign rd     = load && !empty;
  assign wr     = SAMPLE_VALID && SAMPLE_READY;
  assign SAMPLE_READY = (FIFO_LEVEL != LW'(FIFO_DEPTH));

  // Reorder the head frame so the shift register's MSB is always the next serial bit.
  assign head = mem[rptr];
  always_comb begin
    head_ser = '0;
    if (!empty)
      for (int c = 0; c < CHANNELS; c++)
        head_ser[FRAME-1-c*SAMPLE_BITS -: SAMPLE_BITS] = head[c*SAMPLE_BITS +: SAMPLE_BITS];
  end

  always_ff @(posedge CLOCK_IN)
    if (wr) mem[wptr] <= SAMPLE_DATA;

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr       <= '0;
      rptr       <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
        2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
        default: FIFO_LEVEL <= FIFO_LEVEL;
      endcase
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      div     <= '0;
      I2S_BCK <= 1'b0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) I2S_BCK <= ~I2S_BCK;
    end
  end

  // DATA takes the MSB before the shift, giving the one-BCK lag across the frame boundary.
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      k        <= K_LAST;
      sreg     <= '0;
      I2S_DATA <= 1'b0;
      I2S_LRCK <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      UNDERRUN <= load && empty;
      if (fall) begin
        k        <= k_next;
        I2S_DATA <= sreg[FRAME-1];
        I2S_LRCK <= (k_next >= K_HALF);
        sreg     <= load ? head_ser : {sreg[FRAME-2:0], 1'b0};
      end
    end
  end

`ifdef I2S_UNDERRUN_CNT_EN
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N)                              UNDERRUN_CNT <= '0;
    else if (UNDERRUN && UNDERRUN_CNT != 16'hFFFF) UNDERRUN_CNT <= UNDERRUN_CNT + 1'b1;
  end
`endif
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: table-driven frames plus corner sequences, checked by a
// cycle-level scoreboard model of divider, bit index, FIFO and serial stream.
module tb_audio_i2s_tx;
  localparam int SB = 16, CH = 2, FD = 8, CD = 2;
  localparam int FRAME = SB * CH;

  logic              CLOCK_IN = 1'b0;
  logic              RESET_N  = 1'b0;
  logic [FRAME-1:0]  SAMPLE_DATA = '0;
  logic              SAMPLE_VALID = 1'b0;
  logic              SAMPLE_READY, I2S_BCK, I2S_LRCK, I2S_DATA, UNDERRUN;
  logic [3:0]        FIFO_LEVEL;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0]       UNDERRUN_CNT;
`endif

  audio_i2s_tx #(.SAMPLE_BITS(SB), .CHANNELS(CH), .FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (
    .CLOCK_IN(CLOCK_IN), .RESET_N(RESET_N), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_READY(SAMPLE_READY), .I2S_BCK(I2S_BCK),
    .I2S_LRCK(I2S_LRCK), .I2S_DATA(I2S_DATA), .FIFO_LEVEL(FIFO_LEVEL),
`ifdef I2S_UNDERRUN_CNT_EN
    .UNDERRUN_CNT(UNDERRUN_CNT),
`endif
    .UNDERRUN(UNDERRUN));

  always #5 CLOCK_IN = ~CLOCK_IN;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model state
  logic [FRAME-1:0] q[$];
  logic [FRAME-1:0] cur_exp, obs, pend_exp, drv_exp;
  int   n_cyc, mk;
  logic m_lrck, exp_und, pend, cur_loaded;

  always @(negedge CLOCK_IN) begin
    if (!RESET_N) begin
      q.delete();
      n_cyc = 0; mk = FRAME - 1; m_lrck = 0; pend = 0; cur_loaded = 0;
      cur_exp = '0; obs = '0;
      check("rst_bck", 32'(I2S_BCK), 0);
      check("rst_lrck", 32'(I2S_LRCK), 0);
      check("rst_data", 32'(I2S_DATA), 0);
      check("rst_und", 32'(UNDERRUN), 0);
      check("rst_level", 32'(FIFO_LEVEL), 0);
      check("rst_ready", 32'(SAMPLE_READY), 1);
    end else begin
      n_cyc++;
      exp_und = 0;
      if (n_cyc % (2*CD) == 0) begin
        mk = (mk == FRAME-1) ? 0 : mk + 1;
        m_lrck = (mk >= FRAME/2);
        if (mk == 0) begin
          obs[0] = I2S_DATA;
          if (cur_loaded) check("frame", obs, cur_exp);
          if (q.size() > 0) cur_exp = q.pop_front();
          else begin cur_exp = '0; exp_und = 1; end
          cur_loaded = 1;
        end else
          obs[FRAME-mk] = I2S_DATA;
      end
      check("bck", 32'(I2S_BCK), 32'((n_cyc / CD) % 2));
      check("lrck", 32'(I2S_LRCK), 32'(m_lrck));
      check("underrun", 32'(UNDERRUN), 32'(exp_und));
      if (pend) q.push_back(pend_exp);
      check("level", 32'(FIFO_LEVEL), 32'(q.size()));
      check("ready", 32'(SAMPLE_READY), 32'(q.size() != FD));
      pend = SAMPLE_VALID && SAMPLE_READY;
      pend_exp = drv_exp;
    end
  end

  task automatic wait_k(input int target);
    int t = 0;
    do begin @(negedge CLOCK_IN); #1; t++; end while (mk != target && t < 1000);
    if (mk != target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_k: timeout waiting for k=%0d, k=%0d", target, mk);
    end
  endtask

  // Present one frame and hold VALID until it is accepted.
  task automatic send(input logic [FRAME-1:0] d, input logic [FRAME-1:0] e);
    int t = 0;
    logic acc;
    SAMPLE_DATA = d; drv_exp = e; SAMPLE_VALID = 1'b1;
    do begin
      @(negedge CLOCK_IN); acc = SAMPLE_READY;
      @(posedge CLOCK_IN); #1; t++;
    end while (!acc && t < 2000);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send: frame %h not accepted in %0d cycles", d, t);
    end
  endtask

  typedef struct { logic [FRAME-1:0] din; logic [FRAME-1:0] stream; } vec_t;
  vec_t tbl[6];

  initial begin
    logic [FRAME-1:0] r;
    tbl[0] = '{32'h0F0F_A55A, 32'hA55A_0F0F};
    tbl[1] = '{32'h0000_8001, 32'h8001_0000};
    tbl[2] = '{32'hFFFF_0000, 32'h0000_FFFF};
    tbl[3] = '{32'h1234_5678, 32'h5678_1234};
    tbl[4] = '{32'h0001_8000, 32'h8000_0001};
    tbl[5] = '{32'hDEAD_BEEF, 32'hBEEF_DEAD};

    repeat (4) @(negedge CLOCK_IN);
    #1 RESET_N = 1'b1;
    repeat (140) @(negedge CLOCK_IN);   // idle: zero frames with underrun
    @(posedge CLOCK_IN); #1;

    for (int i = 0; i < 6; i++) send(tbl[i].din, tbl[i].stream);
    SAMPLE_VALID = 1'b0;
    repeat (8*128) @(negedge CLOCK_IN);

    // Fill right after a load: 9 back-to-back offers, only 8 fit
    wait_k(1);
    @(posedge CLOCK_IN); #1;
    for (int i = 0; i < 9; i++) begin
      r = $urandom; SAMPLE_DATA = r; drv_exp = {r[15:0], r[31:16]}; SAMPLE_VALID = 1'b1;
      @(posedge CLOCK_IN); #1;
    end
    SAMPLE_VALID = 1'b0;
    @(negedge CLOCK_IN);
    check("full_ready", 32'(SAMPLE_READY), 0);
    check("full_level", 32'(FIFO_LEVEL), 8);
    @(posedge CLOCK_IN); #1;

    // Hold VALID against a full FIFO across loads; pointers wrap
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      send(r, {r[15:0], r[31:16]});
    end
    SAMPLE_VALID = 1'b0;
    repeat (10*128) @(negedge CLOCK_IN);

    // Reset mid-frame with 3 frames queued
    wait_k(1);
    @(posedge CLOCK_IN); #1;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      send(r, {r[15:0], r[31:16]});
    end
    SAMPLE_VALID = 1'b0;
    wait_k(10);
    check("pre_rst_level", 32'(FIFO_LEVEL), 3);
    @(posedge CLOCK_IN); #3 RESET_N = 1'b0;
    #1;
    check("async_level", 32'(FIFO_LEVEL), 0);
    check("async_bck", 32'(I2S_BCK), 0);
    check("async_lrck", 32'(I2S_LRCK), 0);
    check("async_data", 32'(I2S_DATA), 0);
    repeat (3) @(negedge CLOCK_IN);
    #1 RESET_N = 1'b1;
    repeat (300) @(negedge CLOCK_IN);

    check("sb_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
